// File: rtl/uart_pkg.sv
// Shared state types, oversampling constants and the parity helper
// used by the UART stream core.
package uart_pkg;

  localparam int OVERSAMPLE   = 16;
  localparam int SAMPLE_POINT = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP1  = 3'd4,
    TX_STOP2  = 3'd5
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Callers zero-extend the word, so unused upper bits never disturb the result.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head; pointers carry an
// extra MSB so that full and empty are told apart without a counter.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign level     = wr_ptr_r - rd_ptr_r;
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointer advance
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_r <= {(AW + 1){1'b0}};
      rd_ptr_r <= {(AW + 1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (push_ok_s && !rst_i) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_stream_core.sv
// UART datapath with buffered valid/ready streams: shared baud tick,
// TX serializer and 16x-oversampling RX deserializer around two FIFOs.
module uart_stream_core
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_i,
  input  logic [DIV_W-1:0]            clk_div_i,
  input  logic                        parity_en_i,
  input  logic                        parity_odd_i,
  input  logic                        two_stop_i,
  input  logic                        tx_valid_i,
  input  logic [DATA_W-1:0]           tx_data_i,
  output logic                        tx_ready_o,
  output logic                        rx_valid_o,
  output logic [DATA_W-1:0]           rx_data_o,
  input  logic                        rx_ready_i,
  input  logic                        err_clr_i,
  input  logic                        rx_i,
  output logic                        tx_o,
  output logic [$clog2(FIFO_DEPTH):0] tx_level_o,
  output logic [$clog2(FIFO_DEPTH):0] rx_level_o,
  output logic                        rx_int_o,
  output logic                        tx_int_o,
  output logic                        err_int_o,
  output logic                        overrun_o,
  output logic                        parity_err_o,
  output logic                        frame_err_o
);

  localparam logic [3:0] PH_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] PH_SAMPLE = 4'(SAMPLE_POINT - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_W - 1);

  logic [DIV_W-1:0]  div_r, tick_cnt_r;
  logic              tick_s;
  logic              tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
  logic [DATA_W-1:0] tx_head_s;
  logic              rx_push_s, rx_full_s, rx_empty_s;
  tx_state_t         tx_state_r;
  logic [3:0]        tx_phase_r;
  logic [2:0]        tx_bit_r;
  logic [DATA_W-1:0] tx_shift_r;
  logic              tx_par_r, tx_par_en_r, tx_two_stop_r, tx_r;
  logic              tx_bit_end_s, tx_frame_end_s;
  logic              rx_meta_r, rx_sync_r, rx_prev_r, rx_fall_s;
  rx_state_t         rx_state_r;
  logic [3:0]        rx_phase_r;
  logic [2:0]        rx_bit_r;
  logic [DATA_W-1:0] rx_shift_r;
  logic              rx_par_en_r, rx_par_odd_r, rx_par_bad_r;
  logic              rx_sample_s, rx_ovr_set_s, rx_par_set_s, rx_frm_set_s;
  logic              overrun_r, parity_err_r, frame_err_r;

  assign tick_s = (tick_cnt_r == div_r);

  // Baud tick generator; the divider is reloaded only when the count wraps
  always_ff @(posedge clk) begin
    if (rst_i || tick_s) begin
      tick_cnt_r <= {DIV_W{1'b0}};
      div_r      <= clk_div_i;
    end else begin
      tick_cnt_r <= tick_cnt_r + {{(DIV_W - 1){1'b0}}, 1'b1};
    end
  end

  assign tx_push_s = tx_valid_i && !tx_full_s;

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_i(rst_i), .push(tx_push_s), .push_data(tx_data_i), .pop(tx_pop_s),
    .head(tx_head_s), .full(tx_full_s), .empty(tx_empty_s), .level(tx_level_o)
  );

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_i(rst_i), .push(rx_push_s), .push_data(rx_shift_r), .pop(rx_ready_i),
    .head(rx_data_o), .full(rx_full_s), .empty(rx_empty_s), .level(rx_level_o)
  );

  // TX bit boundaries and the pop that starts the next frame
  always_comb begin
    tx_bit_end_s = tick_s && (tx_phase_r == PH_LAST);
    if (tx_bit_end_s && ((tx_state_r == TX_STOP2) || ((tx_state_r == TX_STOP1) && !tx_two_stop_r))) begin
      tx_frame_end_s = 1'b1;
    end else begin
      tx_frame_end_s = 1'b0;
    end
    if (!tx_empty_s && (tx_frame_end_s || ((tx_state_r == TX_IDLE) && tick_s))) begin
      tx_pop_s = 1'b1;
    end else begin
      tx_pop_s = 1'b0;
    end
  end

  // TX frame sequencer; a pop at frame end chains straight into the next start bit
  always_ff @(posedge clk) begin
    if (rst_i) begin
      tx_state_r    <= TX_IDLE;
      tx_phase_r    <= 4'd0;
      tx_bit_r      <= 3'd0;
      tx_shift_r    <= {DATA_W{1'b0}};
      tx_par_r      <= 1'b0;
      tx_par_en_r   <= 1'b0;
      tx_two_stop_r <= 1'b0;
      tx_r          <= 1'b1;
    end else if (tx_pop_s) begin
      tx_state_r    <= TX_START;
      tx_phase_r    <= 4'd0;
      tx_bit_r      <= 3'd0;
      tx_shift_r    <= tx_head_s;
      tx_par_r      <= calc_parity(8'(tx_head_s), parity_odd_i);
      tx_par_en_r   <= parity_en_i;
      tx_two_stop_r <= two_stop_i;
      tx_r          <= 1'b0;
    end else if (tx_frame_end_s) begin
      tx_state_r <= TX_IDLE;
      tx_phase_r <= 4'd0;
      tx_r       <= 1'b1;
    end else if (tick_s && (tx_state_r != TX_IDLE)) begin
      tx_phase_r <= tx_phase_r + 4'd1;
      if (tx_bit_end_s) begin
        case (tx_state_r)
          TX_START: begin
            tx_state_r <= TX_DATA;
            tx_r       <= tx_shift_r[0];
          end
          TX_DATA: begin
            if (tx_bit_r == BIT_LAST) begin
              tx_state_r <= tx_par_en_r ? TX_PARITY : TX_STOP1;
              tx_r       <= tx_par_en_r ? tx_par_r : 1'b1;
            end else begin
              tx_bit_r   <= tx_bit_r + 3'd1;
              tx_shift_r <= {1'b0, tx_shift_r[DATA_W-1:1]};
              tx_r       <= tx_shift_r[1];
            end
          end
          TX_PARITY: begin
            tx_state_r <= TX_STOP1;
            tx_r       <= 1'b1;
          end
          TX_STOP1: begin
            tx_state_r <= TX_STOP2;
            tx_r       <= 1'b1;
          end
          default: begin
            tx_state_r <= TX_IDLE;
            tx_r       <= 1'b1;
          end
        endcase
      end
    end
  end

  // Serial input synchroniser with one extra flop of history for edge detection
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_i;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  assign rx_fall_s = rx_prev_r && !rx_sync_r;

  // RX sample strobes and error/push events raised at the stop-bit sample
  always_comb begin
    rx_sample_s = 1'b0;
    if (tick_s) begin
      case (rx_state_r)
        RX_START:                   rx_sample_s = (rx_phase_r == PH_SAMPLE);
        RX_DATA, RX_PARITY, RX_STOP: rx_sample_s = (rx_phase_r == PH_LAST);
        default:                    rx_sample_s = 1'b0;
      endcase
    end else begin
      rx_sample_s = 1'b0;
    end
    rx_push_s    = rx_sample_s && (rx_state_r == RX_STOP);
    rx_frm_set_s = rx_push_s && !rx_sync_r;
    rx_par_set_s = rx_push_s && rx_par_bad_r;
    rx_ovr_set_s = rx_push_s && rx_full_s;
  end

  // RX frame sequencer; start sample is mid-bit, later samples every 16 ticks
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rx_state_r   <= RX_IDLE;
      rx_phase_r   <= 4'd0;
      rx_bit_r     <= 3'd0;
      rx_shift_r   <= {DATA_W{1'b0}};
      rx_par_en_r  <= 1'b0;
      rx_par_odd_r <= 1'b0;
      rx_par_bad_r <= 1'b0;
    end else if (rx_state_r == RX_IDLE) begin
      if (rx_fall_s) begin
        rx_state_r   <= RX_START;
        rx_phase_r   <= 4'd0;
        rx_bit_r     <= 3'd0;
        rx_par_bad_r <= 1'b0;
        rx_par_en_r  <= parity_en_i;
        rx_par_odd_r <= parity_odd_i;
      end
    end else if (rx_sample_s) begin
      rx_phase_r <= 4'd0;
      case (rx_state_r)
        RX_START: rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
        RX_DATA: begin
          rx_shift_r <= {rx_sync_r, rx_shift_r[DATA_W-1:1]};
          if (rx_bit_r == BIT_LAST) begin
            rx_state_r <= rx_par_en_r ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_r <= rx_bit_r + 3'd1;
          end
        end
        RX_PARITY: begin
          rx_par_bad_r <= (rx_sync_r != calc_parity(8'(rx_shift_r), rx_par_odd_r));
          rx_state_r   <= RX_STOP;
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end else if (tick_s) begin
      rx_phase_r <= rx_phase_r + 4'd1;
    end
  end

  // Sticky error flags; a new event wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst_i) begin
      overrun_r    <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      overrun_r    <= rx_ovr_set_s | (overrun_r & ~err_clr_i);
      parity_err_r <= rx_par_set_s | (parity_err_r & ~err_clr_i);
      frame_err_r  <= rx_frm_set_s | (frame_err_r & ~err_clr_i);
    end
  end

  assign tx_o         = tx_r;
  assign tx_ready_o   = !tx_full_s;
  assign rx_valid_o   = !rx_empty_s;
  assign rx_int_o     = !rx_empty_s;
  assign tx_int_o     = tx_empty_s && (tx_state_r == TX_IDLE);
  assign overrun_o    = overrun_r;
  assign parity_err_o = parity_err_r;
  assign frame_err_o  = frame_err_r;
  assign err_int_o    = overrun_r | parity_err_r | frame_err_r;

endmodule

// File: tb/tb_uart_stream_core.sv
// Self-checking bench for uart_stream_core: waveform, loopback, FIFO limits,
// RX errors, glitch rejection and mid-frame reset against a queue-based model.
module tb_uart_stream_core;

  localparam int DATA_W = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int DIV_W = 16;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i, parity_en_i, parity_odd_i, two_stop_i;
  logic [DIV_W-1:0]  clk_div_i;
  logic              tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i, err_clr_i;
  logic [DATA_W-1:0] tx_data_i, rx_data_o;
  logic              rx_line, tx_o, rx_int_o, tx_int_o, err_int_o;
  logic              overrun_o, parity_err_o, frame_err_o;
  logic [LW-1:0]     tx_level_o, rx_level_o;
  logic              loop_en, rx_drv;

  assign rx_line = loop_en ? tx_o : rx_drv;

  uart_stream_core #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_i(rst_i), .clk_div_i(clk_div_i), .parity_en_i(parity_en_i),
    .parity_odd_i(parity_odd_i), .two_stop_i(two_stop_i), .tx_valid_i(tx_valid_i),
    .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o), .rx_valid_o(rx_valid_o),
    .rx_data_o(rx_data_o), .rx_ready_i(rx_ready_i), .err_clr_i(err_clr_i), .rx_i(rx_line),
    .tx_o(tx_o), .tx_level_o(tx_level_o), .rx_level_o(rx_level_o), .rx_int_o(rx_int_o),
    .tx_int_o(tx_int_o), .err_int_o(err_int_o), .overrun_o(overrun_o),
    .parity_err_o(parity_err_o), .frame_err_o(frame_err_o)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    logic ok;
    int   k;
    tx_valid_i = 1'b1;
    tx_data_i  = d;
    ok = 1'b0;
    k  = 0;
    while (!ok && k < 5000) begin
      ok = tx_ready_o;
      step(1);
      k++;
    end
    tx_valid_i = 1'b0;
    if (!ok) check_eq("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic pop_rx(output logic [7:0] d);
    d = rx_data_o;
    check_eq("rx_valid_on_pop", 32'(rx_valid_o), 32'd1);
    rx_ready_i = 1'b1;
    step(1);
    rx_ready_i = 1'b0;
  endtask

  // Drives one frame onto rx_i at 16 cycles per bit (clk_div = 0).
  task automatic send_rx(input logic [7:0] d, input logic pen, input logic odd,
                         input logic bad_par, input logic stop_bit);
    logic [10:0] bits;
    int          nb;
    bits = 11'd0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nb = 9;
    if (pen) begin
      bits[9] = (^d) ^ odd ^ bad_par;
      nb = 10;
    end
    bits[nb] = stop_bit;
    nb++;
    for (int i = 0; i < nb; i++) begin
      rx_drv = bits[i];
      step(16);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    #5_000_000;
    n_mis++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  d, bits8;
    logic [15:0] vec;
    logic        bitv, stop;
    logic [9:0]  frame1;
    int          k;

    rst_i = 1'b1; clk_div_i = 16'd0; parity_en_i = 1'b0; parity_odd_i = 1'b0;
    two_stop_i = 1'b0; tx_valid_i = 1'b0; tx_data_i = 8'd0; rx_ready_i = 1'b0;
    err_clr_i = 1'b0; loop_en = 1'b0; rx_drv = 1'b1;
    step(3);
    check_eq("rst_tx_o", 32'(tx_o), 32'd1);
    check_eq("rst_tx_ready", 32'(tx_ready_o), 32'd1);
    check_eq("rst_rx_valid", 32'(rx_valid_o), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data_o), 32'd0);
    check_eq("rst_tx_int", 32'(tx_int_o), 32'd1);
    check_eq("rst_levels", {tx_level_o, rx_level_o}, 32'd0);
    check_eq("rst_errs", {overrun_o, parity_err_o, frame_err_o, err_int_o}, 32'd0);
    rst_i = 1'b0;
    step(2);

    // 1: exact 8N1 waveform for 0xA5 at one tick per cycle
    frame1 = {1'b1, 8'hA5, 1'b0};
    push_tx(8'hA5);
    check_eq("t1_level_after_push", 32'(tx_level_o), 32'd1);
    for (int b = 0; b < 10; b++) begin
      bitv = frame1[b];
      vec = 16'd0;
      for (int s = 0; s < 16; s++) begin
        step(1);
        vec[s] = tx_o;
        if (b == 0 && s == 0) check_eq("t1_level_after_pop", 32'(tx_level_o), 32'd0);
        if (b == 9 && s == 15) check_eq("t1_tx_int_in_stop", 32'(tx_int_o), 32'd0);
      end
      check_eq($sformatf("t1_bit%0d", b), 32'(vec), bitv ? 32'h0000_FFFF : 32'd0);
    end
    step(1);
    check_eq("t1_tx_int_after_stop", 32'(tx_int_o), 32'd1);
    check_eq("t1_idle_line", 32'(tx_o), 32'd1);

    // 2: loopback, even parity, clk_div = 3
    loop_en = 1'b1; clk_div_i = 16'd3; parity_en_i = 1'b1; parity_odd_i = 1'b0;
    q = {8'h00, 8'hFF, 8'h3C};
    for (int i = 0; i < 3; i++) q.push_back(8'($urandom_range(0, 255)));
    foreach (q[i]) push_tx(q[i]);
    k = 0;
    while (rx_level_o < 6 && k < 10000) begin step(1); k++; end
    check_eq("t2_rx_level", 32'(rx_level_o), 32'd6);
    check_eq("t2_rx_int", 32'(rx_int_o), 32'd1);
    check_eq("t2_no_errors", {overrun_o, parity_err_o, frame_err_o, err_int_o}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      pop_rx(d);
      check_eq($sformatf("t2_word%0d", i), 32'(d), 32'(q[i]));
    end
    check_eq("t2_rx_drained", 32'(rx_valid_o), 32'd0);
    k = 0;
    while (!tx_int_o && k < 2000) begin step(1); k++; end
    check_eq("t2_tx_done", 32'(tx_int_o), 32'd1);
    loop_en = 1'b0; parity_en_i = 1'b0; clk_div_i = 16'd0;
    step(10);

    // 3: fill TX FIFO while the first tick is far away, then stream with no gaps
    clk_div_i = 16'd200;
    rst_i = 1'b1;
    step(2);
    rst_i = 1'b0;
    q.delete();
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      q.push_back(8'($urandom_range(0, 255)));
      push_tx(q[i]);
    end
    check_eq("t3_level_full", 32'(tx_level_o), 32'd16);
    check_eq("t3_ready_low", 32'(tx_ready_o), 32'd0);
    tx_valid_i = 1'b1;
    tx_data_i  = 8'hEE;
    step(5);
    tx_valid_i = 1'b0;
    check_eq("t3_17th_rejected", 32'(tx_level_o), 32'd16);
    clk_div_i = 16'd0;
    k = 0;
    while (tx_o !== 1'b0 && k < 400) begin step(1); k++; end
    check_eq("t3_first_start", 32'(tx_o), 32'd0);
    for (int f = 0; f < FIFO_DEPTH; f++) begin
      step(8);
      bitv = tx_o;
      for (int i = 0; i < 8; i++) begin
        step(16);
        bits8[i] = tx_o;
      end
      step(16);
      stop = tx_o;
      check_eq($sformatf("t3_word%0d", f), {bitv, stop, bits8}, {1'b0, 1'b1, q[f]});
      step(8);
      if (f < FIFO_DEPTH - 1) check_eq($sformatf("t3_gap%0d", f), 32'(tx_o), 32'd0);
      else check_eq("t3_end", {tx_o, tx_int_o}, 32'd3);
    end

    // 4: overrun with 17 frames and no pops
    q.delete();
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      q.push_back(8'($urandom_range(0, 255)));
      send_rx(q[i], 1'b0, 1'b0, 1'b0, 1'b1);
    end
    step(20);
    check_eq("t4_rx_level", 32'(rx_level_o), 32'd16);
    check_eq("t4_overrun", {overrun_o, err_int_o}, 32'd3);
    check_eq("t4_other_errs", {parity_err_o, frame_err_o}, 32'd0);
    err_clr_i = 1'b1;
    step(1);
    err_clr_i = 1'b0;
    check_eq("t4_overrun_cleared", {overrun_o, err_int_o}, 32'd0);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      pop_rx(d);
      check_eq($sformatf("t4_word%0d", i), 32'(d), 32'(q[i]));
    end
    check_eq("t4_drained", 32'(rx_level_o), 32'd0);

    // 5: odd parity, bad parity bit then a low stop bit
    parity_en_i = 1'b1; parity_odd_i = 1'b1;
    send_rx(8'h01, 1'b1, 1'b1, 1'b1, 1'b1);
    step(10);
    check_eq("t5_parity_err", {parity_err_o, frame_err_o}, 32'd2);
    send_rx(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    step(10);
    check_eq("t5_frame_err", {parity_err_o, frame_err_o, err_int_o}, 32'd7);
    check_eq("t5_rx_level", 32'(rx_level_o), 32'd2);
    pop_rx(d);
    check_eq("t5_word0", 32'(d), 32'h01);
    pop_rx(d);
    check_eq("t5_word1", 32'(d), 32'h5A);

    // 6: clear, glitch rejection, then reset in the middle of a frame
    err_clr_i = 1'b1;
    step(1);
    err_clr_i = 1'b0;
    check_eq("t6_errs_cleared", {parity_err_o, frame_err_o, err_int_o}, 32'd0);
    parity_en_i = 1'b0; parity_odd_i = 1'b0;
    rx_drv = 1'b0;
    step(4);
    rx_drv = 1'b1;
    step(60);
    check_eq("t6_glitch_no_word", 32'(rx_level_o), 32'd0);
    check_eq("t6_glitch_no_err", 32'(err_int_o), 32'd0);
    for (int i = 0; i < 3; i++) push_tx(8'($urandom_range(0, 255)));
    rx_drv = 1'b0;
    step(40);
    check_eq("t6_tx_level_mid", 32'(tx_level_o), 32'd2);
    rst_i = 1'b1;
    step(1);
    rx_drv = 1'b1;
    check_eq("t6_rst_tx_o", 32'(tx_o), 32'd1);
    check_eq("t6_rst_levels", {tx_level_o, rx_level_o}, 32'd0);
    check_eq("t6_rst_flags", {tx_int_o, rx_valid_o}, 32'd2);
    rst_i = 1'b0;
    step(300);
    check_eq("t6_post_tx_idle", {tx_o, tx_int_o}, 32'd3);
    check_eq("t6_post_rx_empty", 32'(rx_level_o), 32'd0);
    check_eq("t6_post_no_err", 32'(err_int_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_stream_core.md
Name: uart_stream_core

Overview:
Parametrised next-generation UART datapath. It replaces the single-byte register hand-off with buffered valid/ready streams on both directions, backed by TX and RX FIFOs. Data width, parity and stop bits are configurable, and RX uses 16x oversampling. It sits below the register block: the register block drives the config inputs and the stream ports.

Parameters:
DATA_W, 8, data bits per frame (5..8), sent LSB first
FIFO_DEPTH, 16, entries per FIFO (power of 2, >=2)
DIV_W, 16, width of the baud divider

Ports:
clk  in  1  clock
rst_i  in  1  synchronous active-high reset
clk_div_i  in  DIV_W  oversample tick period minus 1
parity_en_i  in  1  parity bit present
parity_odd_i  in  1  1=odd, 0=even parity
two_stop_i  in  1  TX sends 2 stop bits
tx_valid_i  in  1  TX stream valid
tx_data_i  in  DATA_W  TX stream data
tx_ready_o  out  1  TX FIFO not full
rx_valid_o  out  1  RX FIFO not empty
rx_data_o  out  DATA_W  RX FIFO head
rx_ready_i  in  1  RX pop
err_clr_i  in  1  clear sticky errors
rx_i  in  1  serial input (async)
tx_o  out  1  serial output
tx_level_o  out  $clog2(FIFO_DEPTH)+1  TX occupancy
rx_level_o  out  $clog2(FIFO_DEPTH)+1  RX occupancy
rx_int_o  out  1  = rx_valid_o
tx_int_o  out  1  TX FIFO empty and TX FSM idle
err_int_o  out  1  OR of sticky errors
overrun_o / parity_err_o / frame_err_o  out  1 each  sticky error flags

Behaviour:
- Reset: tx_o=1, FIFOs empty, levels=0, tx_ready_o=1, rx_valid_o=0, rx_data_o=0, tx_int_o=1, all errors=0, FSMs IDLE, synchroniser flops=1, tick counter=0.
- Tick: free-running counter; one-cycle tick when count==clk_div_i, then wraps to 0. clk_div_i=0 gives a tick every cycle. A config change takes effect at the next wrap.
- Streams: a transfer happens when valid&&ready in the same cycle. Level updates on the next cycle. Simultaneous push and pop on a full or empty FIFO are legal; the level is unchanged when both succeed. rx_data_o is first-word-fall-through.
- TX FSM: IDLE -> START -> DATA -> PARITY (if parity_en) -> STOP1 -> STOP2 (if two_stop) -> IDLE.
  - Leaves IDLE on the first tick with the FIFO non-empty, popping and latching the word; tx_o changes on the following cycle.
  - Each bit lasts exactly 16 ticks. Parity is the XOR of the data bits, inverted if odd.
  - Config is sampled at frame start.
  - Back-to-back words go STOP -> START with no idle gap.
- RX path:
  - 2-flop synchroniser on rx_i.
  - IDLE: a falling edge on the synchronised input starts the 16x phase counter.
  - START: sample at tick 8. If high, it is a false start and the FSM returns to IDLE with no error.
  - DATA/PARITY/STOP: sample every 16 ticks thereafter. RX checks one stop bit only.
  - Parity mismatch sets parity_err_o. A low stop bit sets frame_err_o.
  - The word is pushed on the stop-bit sample even if errored. A push onto a full FIFO drops the word and sets overrun_o.
  - After the stop sample the FSM returns to IDLE immediately, ready for the next edge.
- Errors: sticky until err_clr_i. If a set and err_clr_i occur in the same cycle, set wins.
- Widths: bits above DATA_W are not stored. Levels saturate at FIFO_DEPTH (never wrap).
- rst_i mid-frame: tx_o returns to 1 the next cycle, the partial RX word is discarded, and the FIFOs are flushed.

Decomposition:
- Package uart_pkg: tx_state_t and rx_state_t enums, OVERSAMPLE=16, SAMPLE_POINT=8, and a parity function.
- Sub-module uart_sync_fifo (WIDTH, DEPTH): handles push/pop/full/empty/level with pointer wrap via an extra MSB. It is instantiated twice.
- The tick generator, TX FSM and RX FSM are inline.

Test Plan:
1. clk_div=0, 8N1, push 0xA5 -> tx_o low 16 cycles starting 2 cycles after accept, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles; tx_int_o rises after stop.
2. Loopback rx_i=tx_o, clk_div=3, even parity, push 0x00,0xFF,0x3C -> rx_data_o 0x00,0xFF,0x3C in order, no errors, rx_int_o high.
3. Push FIFO_DEPTH+1 words with TX idle-blocked -> tx_ready_o=0 at level 16, 17th not accepted; all 16 transmitted with no gaps.
4. Drive 17 frames into RX with rx_ready_i=0 -> rx_level_o=16, overrun_o=1, err_int_o=1; err_clr_i pulse clears overrun_o; the 16 stored words match the first 16 sent.
5. Odd parity, send 0x01 with a wrong parity bit, then a frame with stop=0 -> parity_err_o=1 and frame_err_o=1, and both words are still pushed.
6. 4-cycle low glitch on rx_i (clk_div=0) -> no word, no error; rst_i mid-TX-frame -> tx_o=1 next cycle, levels 0.
